uart_rx_oversampler: RTL and testbench

Serial front-end that sits directly upstream of the UART controller's receive path. It oversamples the asynchronous uart_rx line at 16x baud and deframes 8N1 characters, LSB first. It presents each byte on rx_data with an rx_status pulse one bit-time wide, which the controller edge-detects and latches. It also flags framing errors and rejects false start bits.

---
 rtl/uart_rx_oversampler.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_oversampler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampler.sv
// 16x oversampling 8N1 UART receiver front-end.
// Majority-votes three mid-bit samples and flags framing errors.
`timescale 1ns/1ps
module uart_rx_oversampler #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [TW-1:0] TONE = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        s7_q, s7_d;
  logic        s8_q, s8_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_status_q, rx_status_d;
  logic        frame_err_q, frame_err_d;
  logic [3:0]  hcnt_q, hcnt_d;

  logic rx_s;
  logic tick;
  logic maj;
  logic in_frame;

  assign rx_s = sync2_q;
  assign tick = (tcnt_q == TMAX);
  assign maj  = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  assign in_frame = (state_q == S_START) ||
                    (state_q == S_DATA)  ||
                    (state_q == S_STOP);

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tick ? '0 : tcnt_q + TONE;
    scnt_d      = scnt_q;
    bidx_d      = bidx_q;
    shreg_d     = shreg_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    rx_data_d   = rx_data_q;
    rx_status_d = rx_status_q;
    frame_err_d = frame_err_q;
    hcnt_d      = hcnt_q;

    // Status pulse length is counted apart from the frame FSM.
    if (rx_status_q && tick) begin
      if (hcnt_q == 4'd15) begin
        rx_status_d = 1'b0;
        hcnt_d      = 4'd0;
      end else begin
        hcnt_d = hcnt_q + 4'd1;
      end
    end

    if (tick && in_frame) begin
      scnt_d = scnt_q + 4'd1;
      if (scnt_q == 4'd7) s7_d = rx_s;
      if (scnt_q == 4'd8) s8_d = rx_s;
    end

    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            scnt_d  = 4'd0;
          end
        end
        S_START: begin
          if (scnt_q == 4'd9 && maj) begin
            state_d = S_IDLE;
            scnt_d  = 4'd0;
          end else if (scnt_q == 4'd15) begin
            state_d = S_DATA;
            bidx_d  = 3'd0;
          end
        end
        S_DATA: begin
          if (scnt_q == 4'd9) shreg_d = {maj, shreg_q[7:1]};
          if (scnt_q == 4'd15) begin
            bidx_d = bidx_q + 3'd1;
            if (bidx_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (scnt_q == 4'd9) begin
            scnt_d = 4'd0;
            if (maj) begin
              rx_data_d   = shreg_q;
              rx_status_d = 1'b1;
              hcnt_d      = 4'd0;
              frame_err_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      tcnt_q      <= '0;
      scnt_q      <= 4'd0;
      bidx_q      <= 3'd0;
      shreg_q     <= 8'd0;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      hcnt_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      tcnt_q      <= tcnt_d;
      scnt_q      <= scnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      rx_data_q   <= rx_data_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
      hcnt_q      <= hcnt_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_status = rx_status_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = in_frame;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scenario bench for uart_rx_oversampler at DIV=10 (160 cycles/bit).
// Expected bytes are queued at send time and popped on each rx_status rise.
`timescale 1ns/1ps
module tb_uart_rx_oversampler;

  localparam int BIT = 160;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       rx_busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         rise_q[$];
  logic       bsy_q[$];
  int         wid_q[$];
  logic       prev_st = 1'b0;
  int         rise_t = 0;

  uart_rx_oversampler #(
    .CLK_HZ(1600000),
    .BAUD(10000),
    .OVERSAMPLE(16)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .uart_rx(uart_rx),
    .rx_data(rx_data),
    .rx_status(rx_status),
    .frame_err(frame_err),
    .rx_busy(rx_busy)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (rx_status && !prev_st) begin
      obs_q.push_back(rx_data);
      rise_q.push_back(cyc);
      bsy_q.push_back(rx_busy);
      rise_t <= cyc;
    end
    if (!rx_status && prev_st) wid_q.push_back(cyc - rise_t);
    prev_st <= rx_status;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    uart_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(BIT);
    end
    uart_rx = stop_v;
    idle(BIT);
  endtask

  task automatic wait_obs(input int need, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < need && k < 2000) begin
      idle(1);
      k++;
    end
    ok = (obs_q.size() >= need);
  endtask

  task automatic wait_wid(input int need, output bit ok);
    int k;
    k = 0;
    while (wid_q.size() < need && k < 2000) begin
      idle(1);
      k++;
    end
    ok = (wid_q.size() >= need);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    total_cnt++;
    if (rx_data !== 8'h00)
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    else pass_cnt++;
    total_cnt++;
    if (rx_status !== 1'b0)
      $display("FAIL reset_rx_status: got %b want 0", rx_status);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b0)
      $display("FAIL reset_frame_err: got %b want 0", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (rx_busy !== 1'b0)
      $display("FAIL reset_rx_busy: got %b want 0", rx_busy);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    bit ok;
    logic [7:0] got, want;
    logic b;
    int w;
    idle(BIT);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    wait_obs(1, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL basic_data: got no rx_status pulse want 55");
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      void'(rise_q.pop_front());
      b = bsy_q.pop_front();
      if (got !== want)
        $display("FAIL basic_data: got %h want %h", got, want);
      else pass_cnt++;
      total_cnt++;
      if (b !== 1'b0)
        $display("FAIL basic_busy_at_stop: got %b want 0", b);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_err !== 1'b0)
      $display("FAIL basic_frame_err: got %b want 0", frame_err);
    else pass_cnt++;
    wait_wid(1, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL basic_width: got no falling edge want 160");
    end else begin
      w = wid_q.pop_front();
      if (w != 160)
        $display("FAIL basic_width: got %0d want 160", w);
      else pass_cnt++;
    end
  endtask

  task automatic test_false_start;
    bit seen;
    seen = 1'b0;
    idle(BIT);
    uart_rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      seen |= rx_busy;
    end
    uart_rx = 1'b1;
    for (int i = 0; i < 130; i++) begin
      idle(1);
      seen |= rx_busy;
    end
    total_cnt++;
    if (seen !== 1'b1)
      $display("FAIL false_busy_seen: got %b want 1", seen);
    else pass_cnt++;
    total_cnt++;
    if (rx_busy !== 1'b0)
      $display("FAIL false_busy_end: got %b want 0", rx_busy);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != 0)
      $display("FAIL false_no_status: got %0d pulses want 0", obs_q.size());
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h55)
      $display("FAIL false_rx_data: got %h want 55", rx_data);
    else pass_cnt++;
  endtask

  task automatic test_frame_err;
    bit ok;
    bit seen;
    logic [7:0] got, want;
    int w;
    idle(BIT);
    send_byte(8'hA3, 1'b0);
    seen = 1'b0;
    uart_rx = 1'b0;
    for (int i = 0; i < 320; i++) begin
      idle(1);
      seen |= rx_busy;
    end
    total_cnt++;
    if (frame_err !== 1'b1)
      $display("FAIL ferr_flag: got %b want 1", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (seen !== 1'b0)
      $display("FAIL ferr_break_retrigger: got busy=%b want 0", seen);
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h55)
      $display("FAIL ferr_rx_data: got %h want 55", rx_data);
    else pass_cnt++;
    total_cnt++;
    if (obs_q.size() != 0)
      $display("FAIL ferr_no_status: got %0d pulses want 0", obs_q.size());
    else pass_cnt++;
    uart_rx = 1'b1;
    idle(BIT);
    exp_q.push_back(8'h0F);
    send_byte(8'h0F, 1'b1);
    wait_obs(1, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL recover_data: got no rx_status pulse want 0f");
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      void'(rise_q.pop_front());
      void'(bsy_q.pop_front());
      if (got !== want)
        $display("FAIL recover_data: got %h want %h", got, want);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_err !== 1'b0)
      $display("FAIL recover_frame_err: got %b want 0", frame_err);
    else pass_cnt++;
    wait_wid(1, ok);
    w = ok ? wid_q.pop_front() : -1;
    total_cnt++;
    if (w != 160 || obs_q.size() != 0)
      $display("FAIL recover_one_pulse: got width %0d extra %0d want 160 0",
               w, obs_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [7:0] got, want;
    int t0, t1;
    idle(BIT);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_obs(2, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL b2b_count: got %0d pulses want 2", obs_q.size());
      obs_q.delete();
      rise_q.delete();
      bsy_q.delete();
      exp_q.delete();
    end else begin
      pass_cnt++;
      for (int i = 0; i < 2; i++) begin
        got = obs_q.pop_front();
        want = exp_q.pop_front();
        void'(bsy_q.pop_front());
        total_cnt++;
        if (got !== want)
          $display("FAIL b2b_data%0d: got %h want %h", i, got, want);
        else pass_cnt++;
      end
      t0 = rise_q.pop_front();
      t1 = rise_q.pop_front();
      total_cnt++;
      if ((t1 - t0) < 1590 || (t1 - t0) > 1610)
        $display("FAIL b2b_spacing: got %0d want 1600", t1 - t0);
      else pass_cnt++;
    end
    wait_wid(2, ok);
    wid_q.delete();
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [7:0] got, want;
    logic [7:0] b;
    idle(BIT);
    b = 8'h81;
    uart_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      idle(BIT);
    end
    uart_rx = b[4];
    idle(80);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    total_cnt++;
    if ({rx_data, rx_status, frame_err, rx_busy} !== 11'd0)
      $display("FAIL midreset_outputs: got %h/%b/%b/%b want 00/0/0/0",
               rx_data, rx_status, frame_err, rx_busy);
    else pass_cnt++;
    uart_rx = 1'b1;
    idle(2 * BIT);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    wait_obs(1, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL midreset_next: got no rx_status pulse want 3c");
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      void'(rise_q.pop_front());
      void'(bsy_q.pop_front());
      if (got !== want)
        $display("FAIL midreset_next: got %h want %h", got, want);
      else pass_cnt++;
    end
    wait_wid(1, ok);
    wid_q.delete();
  endtask

  task automatic test_glitch;
    bit ok;
    logic [7:0] got, want;
    logic [7:0] b;
    idle(BIT);
    b = 8'h5A;
    exp_q.push_back(b);
    uart_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (i == 2) begin
        idle(90);
        uart_rx = ~b[i];
        idle(10);
        uart_rx = b[i];
        idle(60);
      end else begin
        idle(BIT);
      end
    end
    uart_rx = 1'b1;
    idle(BIT);
    wait_obs(1, ok);
    total_cnt++;
    if (!ok) begin
      $display("FAIL glitch_data: got no rx_status pulse want 5a");
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      void'(rise_q.pop_front());
      void'(bsy_q.pop_front());
      if (got !== want)
        $display("FAIL glitch_data: got %h want %h", got, want);
      else pass_cnt++;
    end
    wait_wid(1, ok);
    wid_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    uart_rx = 1'b1;
    @(negedge sysclk);
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_glitch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
